// File: rtl/dither_arbiter_pkg.sv
// dither_arbiter_pkg: shared widths, channel count, FSM encoding and launch tag layout
package dither_arbiter_pkg;
  localparam int IN_W = 24;
  localparam int OUT_W = 16;
  localparam int N_CH = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic ch;
  } tag_t;
endpackage

// File: rtl/dither_rr_arb.sv
// dither_rr_arb: 2-way fixed/round-robin arbiter, one-hot grant among eligible requesters
module dither_rr_arb import dither_arbiter_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            fixed_prio,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] elig,
  output logic [N_CH-1:0] grant
);
  logic last;
  logic [N_CH-1:0] cand;
  assign cand = req & elig;
  // channel 0 wins under fixed priority, when channel 1 went last, or when alone
  assign grant = (cand[0] && (fixed_prio || last || !cand[1])) ? 2'b01 : {cand[1], 1'b0};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
  end
endmodule

// File: rtl/dither_arbiter.sv
// dither_arbiter: shares one fixed-latency TPDF quantizer between two sample channels
module dither_arbiter import dither_arbiter_pkg::*; #(
  parameter int Q_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic             cfg_fixed_prio,
  input  logic [IN_W-1:0]  req_data0,
  input  logic [IN_W-1:0]  req_data1,
  input  logic [N_CH-1:0]  req_valid,
  output logic [N_CH-1:0]  req_ready,
  output logic [IN_W-1:0]  q_data,
  output logic             q_valid,
  input  logic [OUT_W-1:0] q_result,
  output logic [OUT_W-1:0] out_data0,
  output logic [OUT_W-1:0] out_data1,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic             idle
);
  state_t state, state_nx;
  tag_t [Q_LAT-1:0] pipe;
  tag_t tail;
  logic [N_CH-1:0] busy, elig, land;
  logic run, empty;

  assign tail = pipe[Q_LAT-1];
  assign land = tail.valid ? (tail.ch ? 2'b10 : 2'b01) : 2'b00;
  assign empty = ~|busy;
  assign elig = {N_CH{run}} & ~busy & (~out_valid | out_ready);
  assign q_valid = |req_ready;
  assign q_data = req_ready[0] ? req_data0 : req_ready[1] ? req_data1 : '0;

  always_comb begin
    busy = '0;
    for (int k = 0; k < Q_LAT; k++) if (pipe[k].valid) busy[pipe[k].ch] = 1'b1;
  end

  dither_rr_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .fixed_prio (cfg_fixed_prio),
    .req        (req_valid),
    .elig       (elig),
    .grant      (req_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cfg_en ? RUN : IDLE;
      RUN:     state_nx = cfg_en ? RUN : DRAIN;
      DRAIN:   state_nx = cfg_en ? RUN : (empty && out_valid == '0) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    run = state == RUN;
    idle = state == IDLE && empty && out_valid == '0;
  end

  // a landing result takes precedence over the consumer draining the same buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
      out_valid <= '0;
      out_data0 <= '0;
      out_data1 <= '0;
    end else begin
      pipe[0] <= tag_t'{valid: q_valid, ch: req_ready[1]};
      for (int k = 1; k < Q_LAT; k++) pipe[k] <= pipe[k-1];
      out_valid <= land | (out_valid & ~out_ready);
      if (land[0]) out_data0 <= q_result;
      if (land[1]) out_data1 <= q_result;
    end
  end
endmodule

// File: tb/tb_dither_arbiter.sv
// tb_dither_arbiter: scenario tasks plus a scoreboard fed by grants and drained by output handshakes
module tb_dither_arbiter;
  localparam int QL = 2;
  logic clk = 1'b0, rst = 1'b0, cfg_en = 1'b0, cfg_fixed_prio = 1'b0;
  logic [23:0] req_data0 = '0, req_data1 = '0, q_data;
  logic [1:0] req_valid = '0, req_ready, out_valid, out_ready = 2'b11;
  logic q_valid, idle;
  logic [15:0] q_result, out_data0, out_data1;
  logic [QL-1:0] hv = '0;
  logic [23:0] hd [QL];
  logic [15:0] sb0[$], sb1[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dither_arbiter #(.Q_LAT(QL)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_fixed_prio(cfg_fixed_prio),
    .req_data0(req_data0), .req_data1(req_data1), .req_valid(req_valid), .req_ready(req_ready),
    .q_data(q_data), .q_valid(q_valid), .q_result(q_result),
    .out_data0(out_data0), .out_data1(out_data1), .out_valid(out_valid), .out_ready(out_ready),
    .idle(idle)
  );

  function automatic logic [15:0] quant(input logic [23:0] d);
    return d[23:8] ^ {8'h00, d[7:0]};
  endfunction

  // quantizer stand-in: fixed latency, garbage when no launch is due
  always @(posedge clk) begin
    hv <= {hv[QL-2:0], q_valid};
    hd[0] <= q_data;
    for (int k = 1; k < QL; k++) hd[k] <= hd[k-1];
  end
  assign q_result = hv[QL-1] ? quant(hd[QL-1]) : 16'hdead;

  always @(negedge clk) begin
    if (!rst) begin
      sb0.delete();
      sb1.delete();
    end else begin
      tests++;
      if (req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) begin
        fails++; $display("FAIL grant_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      if (req_ready[0] && req_valid[0]) begin
        tests++;
        if (q_valid !== 1'b1 || q_data !== req_data0) begin
          fails++; $display("FAIL launch0: q_valid=%b q_data=%h required 1 %h", q_valid, q_data, req_data0);
        end
        sb0.push_back(quant(req_data0));
      end
      if (req_ready[1] && req_valid[1]) begin
        tests++;
        if (q_valid !== 1'b1 || q_data !== req_data1) begin
          fails++; $display("FAIL launch1: q_valid=%b q_data=%h required 1 %h", q_valid, q_data, req_data1);
        end
        sb1.push_back(quant(req_data1));
      end
      if (req_ready == 2'b00) begin
        tests++;
        if (q_valid !== 1'b0 || q_data !== 24'h0) begin
          fails++; $display("FAIL q_quiet: q_valid=%b q_data=%h required 0 000000", q_valid, q_data);
        end
      end
      if (out_valid[0] && out_ready[0]) begin
        tests++;
        if (sb0.size() == 0) begin
          fails++; $display("FAIL out0_unexpected: out_data0=%h with no result expected", out_data0);
        end else begin
          logic [15:0] e;
          e = sb0.pop_front();
          if (out_data0 !== e) begin fails++; $display("FAIL out0_data: got %h required %h", out_data0, e); end
        end
      end
      if (out_valid[1] && out_ready[1]) begin
        tests++;
        if (sb1.size() == 0) begin
          fails++; $display("FAIL out1_unexpected: out_data1=%h with no result expected", out_data1);
        end else begin
          logic [15:0] e;
          e = sb1.pop_front();
          if (out_data1 !== e) begin fails++; $display("FAIL out1_data: got %h required %h", out_data1, e); end
        end
      end
    end
  end

  task automatic quiet(input int n);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    cfg_en = 1'b1; req_valid = 2'b11; req_data0 = 24'h0a0b0c; req_data1 = 24'h0d0e0f;
    repeat (2) @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL rst_idle: got %b required 1", idle); end
    tests++; if (req_ready !== 2'b00 || q_valid !== 1'b0 || q_data !== 24'h0) begin
      fails++; $display("FAIL rst_grant: req_ready=%b q_valid=%b q_data=%h required 00 0 0", req_ready, q_valid, q_data);
    end
    tests++; if (out_valid !== 2'b00 || out_data0 !== 16'h0 || out_data1 !== 16'h0) begin
      fails++; $display("FAIL rst_out: out_valid=%b d0=%h d1=%h required 00 0 0", out_valid, out_data0, out_data1);
    end
    @(posedge clk); #1 rst = 1'b1; cfg_en = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single;
    @(posedge clk); #1 cfg_en = 1'b1;
    @(posedge clk); #1 req_data0 = 24'h123456; req_valid = 2'b01;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01 || q_valid !== 1'b1 || q_data !== 24'h123456) begin
      fails++; $display("FAIL single_launch: req_ready=%b q_valid=%b q_data=%h required 01 1 123456", req_ready, q_valid, q_data);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    for (int k = 1; k <= QL + 1; k++) begin
      @(negedge clk);
      tests++; if (out_valid[0] !== (k == QL + 1)) begin
        fails++; $display("FAIL single_out_valid: cycle +%0d got %b required %b", k, out_valid[0], k == QL + 1);
      end
    end
    tests++; if (out_data0 !== quant(24'h123456)) begin
      fails++; $display("FAIL single_out_data: got %h required %h", out_data0, quant(24'h123456));
    end
  endtask

  task automatic test_rr;
    int prev, n, ch;
    int last [2];
    prev = 0; n = 0; last[0] = -10; last[1] = -10;
    cfg_fixed_prio = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 req_data0 = {8'h10, 8'(c), 8'h5a}; req_data1 = {8'h20, 8'(c), 8'ha5}; req_valid = 2'b11;
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ch = req_ready[1] ? 1 : 0;
        tests++; if (ch == prev) begin fails++; $display("FAIL rr_order: cycle %0d got ch%0d required ch%0d", c, ch, 1 - prev); end
        tests++; if (c - last[ch] < QL + 1) begin fails++; $display("FAIL rr_rate: ch%0d gap %0d required >= %0d", ch, c - last[ch], QL + 1); end
        prev = ch; last[ch] = c; n++;
      end
    end
    tests++; if (n != 8) begin fails++; $display("FAIL rr_count: got %0d grants required 8", n); end
  endtask

  task automatic test_fixed;
    int g0, g1;
    logic e0, e1;
    logic [1:0] exp_g;
    @(posedge clk); #1 cfg_fixed_prio = 1'b1; req_data0 = 24'h3a0001; req_valid = 2'b01;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL fixed_seed: got %b required 01", req_ready); end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (QL + 1) @(posedge clk);
    g0 = -10; g1 = -10;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 req_data0 = {8'h30, 8'(c), 8'h01}; req_data1 = {8'h31, 8'(c), 8'h02}; req_valid = 2'b11;
      @(negedge clk);
      e0 = (c - g0) > QL; e1 = (c - g1) > QL;
      exp_g = e0 ? 2'b01 : e1 ? 2'b10 : 2'b00;
      tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL fixed_grant: cycle %0d got %b required %b", c, req_ready, exp_g); end
      if (exp_g[0]) g0 = c;
      if (exp_g[1]) g1 = c;
    end
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1 cfg_fixed_prio = 1'b0; out_ready = 2'b01; req_data1 = 24'h4b4b4b; req_valid = 2'b10;
    @(negedge clk);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_first: got %b required 10", req_ready); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1 req_data1 = {8'h4c, 8'(c), 8'h00};
      @(negedge clk);
      tests++; if (req_ready[1] !== 1'b0) begin fails++; $display("FAIL bp_stall: cycle %0d req_ready[1]=%b required 0", c, req_ready[1]); end
    end
    tests++; if (out_valid[1] !== 1'b1) begin fails++; $display("FAIL bp_hold: out_valid[1]=%b required 1", out_valid[1]); end
    @(posedge clk); #1 out_ready = 2'b11;
    @(negedge clk);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_release: got %b required 10", req_ready); end
  endtask

  task automatic test_drain;
    logic done;
    @(posedge clk); #1 out_ready = 2'b00; req_data0 = 24'h5a0000; req_data1 = 24'h5b0000; req_valid = 2'b11;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL drain_g0: got %b required 01", req_ready); end
    @(posedge clk); #1 req_data1 = 24'h5b1111;
    @(negedge clk);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL drain_g1: got %b required 10", req_ready); end
    @(posedge clk); #1 cfg_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL drain_nogrant: cycle %0d got %b required 00", k, req_ready); end
    end
    tests++; if (out_valid !== 2'b11 || idle !== 1'b0) begin
      fails++; $display("FAIL drain_full: out_valid=%b idle=%b required 11 0", out_valid, idle);
    end
    @(posedge clk); #1 out_ready = 2'b11; req_valid = 2'b00;
    done = 1'b0;
    for (int k = 0; k < 6; k++) if (!done) begin
      @(negedge clk);
      done = idle;
    end
    tests++; if (!done) begin fails++; $display("FAIL drain_idle: idle=%b required 1 within 6 cycles", idle); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1 cfg_en = 1'b1; req_valid = 2'b11; req_data0 = 24'h6a6a6a; req_data1 = 24'h6b6b6b;
    repeat (2) @(negedge clk);
    tests++; if (req_ready === 2'b00) begin fails++; $display("FAIL rm_launch: req_ready=%b required a grant", req_ready); end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    tests++; if (idle !== 1'b1 || req_ready !== 2'b00 || q_valid !== 1'b0 || q_data !== 24'h0) begin
      fails++; $display("FAIL rm_ctrl: idle=%b req_ready=%b q_valid=%b q_data=%h required 1 00 0 0", idle, req_ready, q_valid, q_data);
    end
    tests++; if (out_valid !== 2'b00 || out_data0 !== 16'h0 || out_data1 !== 16'h0) begin
      fails++; $display("FAIL rm_out: out_valid=%b d0=%h d1=%h required 00 0 0", out_valid, out_data0, out_data1);
    end
    @(posedge clk); #1 rst = 1'b1; req_valid = 2'b00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++; if (out_valid !== 2'b00) begin fails++; $display("FAIL rm_ghost: cycle %0d out_valid=%b required 00", k, out_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    quiet(3);
    test_rr;
    quiet(4);
    test_fixed;
    quiet(4);
    test_backpressure;
    quiet(4);
    test_drain;
    test_reset_mid;
    tests++;
    if (sb0.size() + sb1.size() != 0) begin
      fails++; $display("FAIL sb_leftover: %0d results never delivered, required 0", sb0.size() + sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
